// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter feeding the 2:1 mux select, with a bounded burst per grant
// so a continuously requesting source cannot starve the other one.
module mux_select_arbiter #(
  parameter int BURST_MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_ready,
  output logic o_sel,
  output logic o_grant0,
  output logic o_grant1,
  output logic o_valid
);

  // state | meaning
  // IDLE  | no source owns the path; o_sel holds its last value
  // OWN0  | source 0 owns the path, o_sel = 0
  // OWN1  | source 1 owns the path, o_sel = 1

  localparam int CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            sel_q, sel_d;
  logic            grant0_q, grant0_d;
  logic            grant1_q, grant1_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cur;
  logic            own_valid;
  logic            oth_valid;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    cur       = (state_q == OWN1);
    own_valid = cur ? i_valid1 : i_valid0;
    oth_valid = cur ? i_valid0 : i_valid1;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_valid0 && i_valid1) begin
          state_d = last_q ? OWN0 : OWN1;
          sel_d   = ~last_q;
        end else if (i_valid0) begin
          state_d = OWN0;
          sel_d   = 1'b0;
        end else if (i_valid1) begin
          state_d = OWN1;
          sel_d   = 1'b1;
        end
      end
      OWN0, OWN1: begin
        if (!own_valid) begin
          cnt_d  = '0;
          last_d = cur;
          if (oth_valid) begin
            state_d = cur ? OWN0 : OWN1;
            sel_d   = ~cur;
          end else begin
            state_d = IDLE;
          end
        end else if (i_ready) begin
          // Terminal count ends the burst; hand over only if the other side waits.
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (oth_valid) begin
              state_d = cur ? OWN0 : OWN1;
              sel_d   = ~cur;
              last_d  = cur;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    grant0_d = (state_d == OWN0);
    grant1_d = (state_d == OWN1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_sel    = sel_q;
  assign o_grant0 = grant0_q;
  assign o_grant1 = grant1_q;
  assign o_valid  = (grant0_q & i_valid0) | (grant1_q & i_valid1);

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Scoreboarded bench: two arbiters (BURST_MAX = 4 and 1); stimulus queues the expected
// served source per transfer, monitors pop and compare against o_sel on each transfer.
module tb_mux_select_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic a_v0 = 1'b0, a_v1 = 1'b0, a_rdy = 1'b0;
  logic a_sel, a_g0, a_g1, a_vld;
  logic b_v0 = 1'b0, b_v1 = 1'b0, b_rdy = 1'b0;
  logic b_sel, b_g0, b_g1, b_vld;

  int n_vec = 0;
  int n_err = 0;
  logic qa[$];
  logic qb[$];

  always #5 clk = ~clk;

  mux_select_arbiter #(.BURST_MAX(4)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid0(a_v0), .i_valid1(a_v1), .i_ready(a_rdy),
    .o_sel(a_sel), .o_grant0(a_g0), .o_grant1(a_g1), .o_valid(a_vld)
  );

  mux_select_arbiter #(.BURST_MAX(1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid0(b_v0), .i_valid1(b_v1), .i_ready(b_rdy),
    .o_sel(b_sel), .o_grant0(b_g0), .o_grant1(b_g1), .o_valid(b_vld)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfers are judged mid-cycle, away from the edge that samples them.
  always @(negedge clk) begin
    if (rst_n && a_vld && a_rdy) begin
      if (qa.size() == 0) chk("a_unexpected_xfer", 32'(a_sel), 32'hdead);
      else chk("a_xfer_src", 32'(a_sel), 32'(qa.pop_front()));
    end
    if (rst_n && b_vld && b_rdy) begin
      if (qb.size() == 0) chk("b_unexpected_xfer", 32'(b_sel), 32'hdead);
      else chk("b_xfer_src", 32'(b_sel), 32'(qb.pop_front()));
    end
    if (a_g0 && a_g1) chk("a_grant_onehot", 32'd1, 32'd0);
    if (b_g0 && b_g1) chk("b_grant_onehot", 32'd1, 32'd0);
  end

  task automatic step_a(input logic v0, input logic v1, input logic r);
    a_v0 = v0; a_v1 = v1; a_rdy = r;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic v0, input logic v1, input logic r);
    b_v0 = v0; b_v1 = v1; b_rdy = r;
    @(posedge clk); #1;
  endtask

  task automatic push_a(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) qa.push_back(bits[i]);
  endtask

  task automatic push_b(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) qb.push_back(bits[i]);
  endtask

  task automatic chk_a(input string name, input logic g0, input logic g1, input logic s, input logic v);
    chk({name, "_g0"}, 32'(a_g0), 32'(g0));
    chk({name, "_g1"}, 32'(a_g1), 32'(g1));
    chk({name, "_sel"}, 32'(a_sel), 32'(s));
    chk({name, "_vld"}, 32'(a_vld), 32'(v));
  endtask

  task automatic chk_b(input string name, input logic g0, input logic g1, input logic s, input logic v);
    chk({name, "_g0"}, 32'(b_g0), 32'(g0));
    chk({name, "_g1"}, 32'(b_g1), 32'(g1));
    chk({name, "_sel"}, 32'(b_sel), 32'(s));
    chk({name, "_vld"}, 32'(b_vld), 32'(v));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_v0 = 1'b1; a_v1 = 1'b1; a_rdy = 1'b1;
    b_v0 = 1'b1; b_v1 = 1'b1; b_rdy = 1'b1;
    @(posedge clk); #1;
    chk_a("a_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_b("b_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    a_v0 = 1'b0; a_v1 = 1'b0; a_rdy = 1'b0;
    b_v0 = 1'b0; b_v1 = 1'b0; b_rdy = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single requester: grant after one edge, a transfer every cycle.
    do_reset();
    a_v0 = 1'b1; a_rdy = 1'b1; #1;
    chk_a("a_idle_pre", 1'b0, 1'b0, 1'b0, 1'b0);
    step_a(1, 0, 1);
    chk_a("a_first_grant", 1'b1, 1'b0, 1'b0, 1'b1);
    push_a(16'b000000, 6);
    repeat (6) step_a(1, 0, 1);
    chk_a("a_no_switch", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("a_q_empty_1", 32'(qa.size()), 32'd0);

    // Both requesting: 4/4 bursts, no idle cycles.
    do_reset();
    step_a(1, 1, 1);
    chk_a("a_tie_src0", 1'b1, 1'b0, 1'b0, 1'b1);
    push_a(16'b0000111100001111, 16);
    repeat (16) step_a(1, 1, 1);
    chk("a_q_empty_2", 32'(qa.size()), 32'd0);

    // Stall mid-burst at count 2: everything frozen, then 2 more before switching.
    push_a(16'b00, 2);
    repeat (2) step_a(1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step_a(1, 1, 0);
      chk_a("a_hold", 1'b1, 1'b0, 1'b0, 1'b1);
    end
    push_a(16'b001111, 6);
    repeat (6) step_a(1, 1, 1);
    chk_a("a_after_hold", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("a_q_empty_3", 32'(qa.size()), 32'd0);

    // Owner drops while other requests: immediate handover with fresh count.
    push_a(16'b0, 1);
    step_a(1, 1, 1);
    step_a(0, 1, 1);
    chk_a("a_drop_switch", 1'b0, 1'b1, 1'b1, 1'b1);
    push_a(16'b11110, 5);
    repeat (5) step_a(1, 1, 1);
    chk("a_q_empty_4", 32'(qa.size()), 32'd0);

    // Owner drops with nobody else: back to IDLE, o_sel holds 0.
    step_a(0, 0, 1);
    chk_a("a_to_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    step_a(0, 0, 0);
    chk_a("a_idle_hold", 1'b0, 1'b0, 1'b0, 1'b0);

    // BURST_MAX = 1: strict alternation, and tie after serving 0 goes to 1.
    step_b(1, 1, 1);
    chk_b("b_first", 1'b1, 1'b0, 1'b0, 1'b1);
    push_b(16'b010101, 6);
    repeat (6) step_b(1, 1, 1);
    chk("b_q_empty_1", 32'(qb.size()), 32'd0);
    step_b(0, 0, 1);
    chk_b("b_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    step_b(1, 1, 1);
    chk_b("b_tie_src1", 1'b0, 1'b1, 1'b1, 1'b1);
    push_b(16'b10, 2);
    repeat (2) step_b(1, 1, 1);
    chk("b_q_empty_2", 32'(qb.size()), 32'd0);

    // Asynchronous reset mid-burst in OWN1.
    do_reset();
    step_a(0, 1, 1);
    push_a(16'b11, 2);
    repeat (2) step_a(0, 1, 1);
    chk_a("a_own1", 1'b0, 1'b1, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_a("a_async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step_a(1, 1, 1);
    chk_a("a_post_rst_tie", 1'b1, 1'b0, 1'b0, 1'b1);
    push_a(16'b0, 1);
    step_a(1, 1, 1);
    step_a(0, 0, 0);
    chk("a_q_empty_5", 32'(qa.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
